// File: rtl/ide_taskfile_target.sv
// Emulated ATA PIO target: task file, status/IRQ, 256-word sector buffer and
// a request/done handshake toward the host-side storage agent.
module ide_taskfile_target #(
  parameter logic [7:0]  IDLE_STATUS  = 8'h50,
  parameter int unsigned SECTOR_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ide_cs1fx,
  input  logic        ide_cs3fx,
  input  logic        ide_io_read_n,
  input  logic        ide_io_write_n,
  input  logic [2:0]  ide_address,
  input  logic [15:0] ide_data_bus_in,
  output logic [15:0] ide_data_bus_out,
  output logic        ide_irq,
  output logic        host_req,
  output logic [7:0]  host_cmd,
  output logic [27:0] host_lba,
  input  logic [7:0]  host_addr,
  input  logic        host_wr,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata,
  input  logic        host_done,
  input  logic        host_error
);
  localparam int unsigned PW = $clog2(SECTOR_WORDS);
  localparam logic [7:0] STAT_BSY = 8'h80;
  localparam logic [7:0] STAT_DRQ = 8'h58;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_PIO_OUT, S_PIO_IN, S_DRAIN} state_t;
  state_t state, state_n;

  logic          rd_n_q, wr_n_q, cs1_q, cs3_q;
  logic [2:0]    addr_q;
  logic [15:0]   wdata_q;
  logic [7:0]    error_r, count;
  logic [27:0]   lba;
  logic [3:0]    dev_hi;
  logic          nien, srst, err_flag, irq_q;
  logic [PW-1:0] ptr;
  logic [15:0]   mem [SECTOR_WORDS];
  logic [15:0]   prefetch;
  logic [7:0]    status;

  logic rd_ev, wr_ev, tf_rd, tf_wr, ctl_wr;
  logic data_rd_ev, data_wr_ev, status_rd_ev, cmd_ev;
  logic accept, quick, abort, step, ptr_clr, ptr_inc, buf_we, irq_set;

  // Strobe sampling: select and address are captured while a strobe is low,
  // so the event on the rising strobe uses what the adapter presented.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      cs1_q   <= 1'b1;
      cs3_q   <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      rd_n_q <= ide_io_read_n;
      wr_n_q <= ide_io_write_n;
      if (!ide_io_read_n || !ide_io_write_n) begin
        cs1_q  <= ide_cs1fx;
        cs3_q  <= ide_cs3fx;
        addr_q <= ide_address;
      end
      if (!ide_io_write_n) wdata_q <= ide_data_bus_in;
    end
  end

  assign rd_ev        = ide_io_read_n && !rd_n_q;
  assign wr_ev        = ide_io_write_n && !wr_n_q;
  assign tf_rd        = rd_ev && !cs1_q;
  assign tf_wr        = wr_ev && !cs1_q;
  assign ctl_wr       = wr_ev && cs1_q && !cs3_q && (addr_q == 3'd6);
  assign data_rd_ev   = tf_rd && (addr_q == 3'd0);
  assign status_rd_ev = tf_rd && (addr_q == 3'd7);
  assign data_wr_ev   = tf_wr && (addr_q == 3'd0);
  assign cmd_ev       = tf_wr && (addr_q == 3'd7);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     state <= S_IDLE;
    else if (srst) state <= S_IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    quick   = 1'b0;
    abort   = 1'b0;
    step    = 1'b0;
    ptr_clr = 1'b0;
    ptr_inc = 1'b0;
    buf_we  = 1'b0;
    irq_set = 1'b0;
    if (!srst) begin
      case (state)
        S_IDLE: if (cmd_ev) begin
          case (wdata_q[7:0])
            8'h20, 8'h21, 8'hEC: begin
              if (dev_hi[2]) begin accept = 1'b1; state_n = S_FILL; end
              else abort = 1'b1;
            end
            8'h30, 8'h31: begin
              if (dev_hi[2]) begin accept = 1'b1; ptr_clr = 1'b1; state_n = S_PIO_IN; end
              else abort = 1'b1;
            end
            8'h91, 8'hEF, 8'hC6: quick = 1'b1;
            default: abort = 1'b1;
          endcase
        end
        S_FILL: if (host_done) begin
          if (host_error) begin abort = 1'b1; state_n = S_IDLE; end
          else begin ptr_clr = 1'b1; irq_set = 1'b1; state_n = S_PIO_OUT; end
        end
        S_PIO_OUT: if (data_rd_ev) begin
          ptr_inc = 1'b1;
          if (ptr == '1) begin
            step    = 1'b1;
            state_n = (host_cmd == 8'hEC || count == 8'd1) ? S_IDLE : S_FILL;
          end
        end
        S_PIO_IN: if (data_wr_ev) begin
          buf_we  = 1'b1;
          ptr_inc = 1'b1;
          if (ptr == '1) state_n = S_DRAIN;
        end
        S_DRAIN: if (host_done) begin
          if (host_error) begin abort = 1'b1; state_n = S_IDLE; end
          else begin
            step    = 1'b1;
            irq_set = 1'b1;
            state_n = (count == 8'd1) ? S_IDLE : S_PIO_IN;
          end
        end
        default: state_n = S_IDLE;
      endcase
      if (abort || quick) irq_set = 1'b1;
    end
  end

  assign host_req = (state == S_FILL) || (state == S_DRAIN);
  assign ide_irq  = irq_q;

  // While SRST is held every task-file register sits at its reset value, so
  // releasing it leaves the device in the power-on state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error_r    <= 8'h01;
      count      <= 8'd1;
      lba        <= 28'd1;
      dev_hi     <= 4'hE;
      nien       <= 1'b0;
      srst       <= 1'b0;
      err_flag   <= 1'b0;
      irq_q      <= 1'b0;
      ptr        <= '0;
      host_cmd   <= '0;
      host_lba   <= '0;
      prefetch   <= '0;
      host_rdata <= '0;
    end else begin
      if (ctl_wr) begin
        nien <= wdata_q[1];
        srst <= wdata_q[2];
      end
      prefetch <= mem[ptr];
      if (srst) begin
        error_r    <= 8'h01;
        count      <= 8'd1;
        lba        <= 28'd1;
        dev_hi     <= 4'hE;
        err_flag   <= 1'b0;
        ptr        <= '0;
        host_cmd   <= '0;
        host_lba   <= '0;
        host_rdata <= '0;
      end else begin
        host_rdata <= mem[host_addr[PW-1:0]];
        if (state == S_IDLE && tf_wr) begin
          case (addr_q)
            3'd2: count      <= wdata_q[7:0];
            3'd3: lba[7:0]   <= wdata_q[7:0];
            3'd4: lba[15:8]  <= wdata_q[7:0];
            3'd5: lba[23:16] <= wdata_q[7:0];
            3'd6: begin
              dev_hi      <= wdata_q[7:4];
              lba[27:24]  <= wdata_q[3:0];
            end
            default: ;
          endcase
        end
        if (accept) begin
          host_cmd <= wdata_q[7:0];
          host_lba <= lba;
          error_r  <= 8'h00;
          err_flag <= 1'b0;
        end
        if (quick) err_flag <= 1'b0;
        if (abort) begin
          error_r  <= 8'h04;
          err_flag <= 1'b1;
        end
        if (step) begin
          count    <= count - 8'd1;
          lba      <= lba + 28'd1;
          host_lba <= lba + 28'd1;
        end
        if (ptr_clr)      ptr <= '0;
        else if (ptr_inc) ptr <= ptr + 1'b1;
      end
      if (srst || nien)      irq_q <= 1'b0;
      else if (irq_set)      irq_q <= 1'b1;
      else if (status_rd_ev) irq_q <= 1'b0;
    end
  end

  // IDE write is ordered last so it wins a same-word collision with the host.
  always_ff @(posedge clock) begin
    if (host_wr) mem[host_addr[PW-1:0]] <= host_wdata;
    if (buf_we)  mem[ptr] <= wdata_q;
  end

  always_comb begin
    status = IDLE_STATUS | {7'd0, err_flag};
    if (srst) status = STAT_BSY;
    else begin
      case (state)
        S_FILL, S_DRAIN:     status = STAT_BSY;
        S_PIO_OUT, S_PIO_IN: status = STAT_DRQ;
        default: ;
      endcase
    end
  end

  always_comb begin
    ide_data_bus_out = 16'hFFFF;
    if (!ide_io_read_n) begin
      if (!ide_cs1fx) begin
        case (ide_address)
          3'd0:    ide_data_bus_out = prefetch;
          3'd1:    ide_data_bus_out = {8'h00, error_r};
          3'd2:    ide_data_bus_out = {8'h00, count};
          3'd3:    ide_data_bus_out = {8'h00, lba[7:0]};
          3'd4:    ide_data_bus_out = {8'h00, lba[15:8]};
          3'd5:    ide_data_bus_out = {8'h00, lba[23:16]};
          3'd6:    ide_data_bus_out = {8'h00, dev_hi, lba[27:24]};
          default: ide_data_bus_out = {8'h00, status};
        endcase
      end else if (!ide_cs3fx) begin
        ide_data_bus_out = (ide_address == 3'd6) ? {8'h00, status} : 16'h00FF;
      end
    end
  end
endmodule

// File: tb/tb_ide_taskfile_target.sv
// Self-checking bench for ide_taskfile_target: register-level IDE cycles and
// host handshakes checked against expectations derived from the ATA rules.
module tb_ide_taskfile_target;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ide_cs1fx = 1'b1, ide_cs3fx = 1'b1;
  logic        ide_io_read_n = 1'b1, ide_io_write_n = 1'b1;
  logic [2:0]  ide_address = '0;
  logic [15:0] ide_data_bus_in = '0;
  logic [15:0] ide_data_bus_out;
  logic        ide_irq, host_req;
  logic [7:0]  host_cmd;
  logic [27:0] host_lba;
  logic [7:0]  host_addr = '0;
  logic        host_wr = 1'b0;
  logic [15:0] host_wdata = '0;
  logic [15:0] host_rdata;
  logic        host_done = 1'b0, host_error = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [15:0] sector [256];
  logic irq_mon = 1'b0;
  logic irq_seen = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) if (irq_mon && ide_irq) irq_seen <= 1'b1;

  ide_taskfile_target #(.IDLE_STATUS(8'h50), .SECTOR_WORDS(256)) dut (
    .clock(clock), .reset(reset),
    .ide_cs1fx(ide_cs1fx), .ide_cs3fx(ide_cs3fx),
    .ide_io_read_n(ide_io_read_n), .ide_io_write_n(ide_io_write_n),
    .ide_address(ide_address), .ide_data_bus_in(ide_data_bus_in),
    .ide_data_bus_out(ide_data_bus_out), .ide_irq(ide_irq),
    .host_req(host_req), .host_cmd(host_cmd), .host_lba(host_lba),
    .host_addr(host_addr), .host_wr(host_wr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_done(host_done), .host_error(host_error)
  );

  // ctl=1 selects the control block (cs3fx), ctl=0 the command block (cs1fx).
  task automatic rd(input bit ctl, input logic [2:0] a, output logic [15:0] d);
    @(negedge clock);
    ide_cs1fx = ctl; ide_cs3fx = !ctl; ide_address = a; ide_io_read_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    d = ide_data_bus_out;
    ide_io_read_n = 1'b1;
    @(negedge clock);
    ide_cs1fx = 1'b1; ide_cs3fx = 1'b1;
    @(negedge clock);
  endtask

  task automatic wr(input bit ctl, input logic [2:0] a, input logic [15:0] v);
    @(negedge clock);
    ide_cs1fx = ctl; ide_cs3fx = !ctl; ide_address = a;
    ide_data_bus_in = v; ide_io_write_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    ide_io_write_n = 1'b1;
    @(negedge clock);
    ide_cs1fx = 1'b1; ide_cs3fx = 1'b1;
    @(negedge clock);
  endtask

  task automatic issue(input logic [7:0] cnt, input logic [27:0] l, input logic [3:0] devhi,
                       input logic [7:0] cmd);
    wr(0, 3'd2, {8'h00, cnt});
    wr(0, 3'd3, {8'h00, l[7:0]});
    wr(0, 3'd4, {8'h00, l[15:8]});
    wr(0, 3'd5, {8'h00, l[23:16]});
    wr(0, 3'd6, {8'h00, devhi, l[27:24]});
    wr(0, 3'd7, {8'h00, cmd});
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!host_req && n < 100) begin @(negedge clock); n++; end
    checks++;
    if (host_req !== 1'b1) begin errors++; $display("FAIL %s host_req timeout got %b exp 1", name, host_req); end
  endtask

  task automatic host_fill(input bit rnd);
    for (int i = 0; i < 256; i++) begin
      sector[i] = rnd ? 16'($urandom) : 16'(i);
      @(negedge clock);
      host_wr = 1'b1; host_addr = 8'(i); host_wdata = sector[i];
    end
    @(negedge clock);
    host_wr = 1'b0;
  endtask

  task automatic pulse_done(input bit err);
    @(negedge clock);
    host_done = 1'b1; host_error = err;
    @(negedge clock);
    host_done = 1'b0; host_error = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    logic [7:0] exp_regs [8];
    exp_regs = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'hE0, 8'h50};
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checks++; if (ide_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", ide_irq); end
    checks++; if (host_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", host_req); end
    checks++; if (host_lba !== 28'd0) begin errors++; $display("FAIL reset_lba got %h exp 0", host_lba); end
    for (int r = 1; r < 8; r++) begin
      rd(0, 3'(r), d);
      checks++;
      if (d !== {8'h00, exp_regs[r]}) begin errors++; $display("FAIL reset_reg%0d got %h exp %h", r, d, {8'h00, exp_regs[r]}); end
    end
    @(negedge clock);
    ide_io_read_n = 1'b0;
    @(negedge clock);
    checks++; if (ide_data_bus_out !== 16'hFFFF) begin errors++; $display("FAIL unselected got %h exp FFFF", ide_data_bus_out); end
    ide_io_read_n = 1'b1;
    rd(1, 3'd2, d);
    checks++; if (d !== 16'h00FF) begin errors++; $display("FAIL ctl_other got %h exp 00FF", d); end
  endtask

  task automatic test_read_cmd();
    logic [15:0] d;
    logic [27:0] l, l2;
    int bad;
    l = 28'($urandom_range(0, 28'h0FFFFF0));
    issue(8'd2, l, 4'hE, 8'h20);
    rd(1, 3'd6, d);
    checks++; if (d !== 16'h0080) begin errors++; $display("FAIL rd_busy got %h exp 0080", d); end
    checks++; if (host_req !== 1'b1) begin errors++; $display("FAIL rd_req got %b exp 1", host_req); end
    checks++; if (host_lba !== l) begin errors++; $display("FAIL rd_lba got %h exp %h", host_lba, l); end
    checks++; if (host_cmd !== 8'h20) begin errors++; $display("FAIL rd_cmd got %h exp 20", host_cmd); end
    for (int s = 0; s < 2; s++) begin
      if (s == 1) begin
        wait_req("rd_second");
        checks++; if (host_lba !== l + 28'd1) begin errors++; $display("FAIL rd_lba2 got %h exp %h", host_lba, l + 28'd1); end
      end
      host_fill(1'b1);
      pulse_done(1'b0);
      checks++; if (ide_irq !== 1'b1) begin errors++; $display("FAIL rd_irq got %b exp 1", ide_irq); end
      checks++; if (host_req !== 1'b0) begin errors++; $display("FAIL rd_req_drop got %b exp 0", host_req); end
      rd(0, 3'd7, d);
      checks++; if (d !== 16'h0058) begin errors++; $display("FAIL rd_drq got %h exp 0058", d); end
      checks++; if (ide_irq !== 1'b0) begin errors++; $display("FAIL rd_irq_clr got %b exp 0", ide_irq); end
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        rd(0, 3'd0, d);
        checks++;
        if (d !== sector[i]) begin
          errors++;
          if (bad++ < 4) $display("FAIL rd_data s%0d w%0d got %h exp %h", s, i, d, sector[i]);
        end
      end
    end
    l2 = l + 28'd2;
    rd(0, 3'd7, d);
    checks++; if (d !== 16'h0050) begin errors++; $display("FAIL rd_end_status got %h exp 0050", d); end
    rd(0, 3'd2, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rd_end_count got %h exp 0000", d); end
    rd(0, 3'd3, d);
    checks++; if (d !== {8'h00, l2[7:0]}) begin errors++; $display("FAIL rd_end_lba0 got %h exp %h", d, l2[7:0]); end
    rd(0, 3'd6, d);
    checks++; if (d !== {12'h00E, l2[27:24]}) begin errors++; $display("FAIL rd_end_dev got %h exp %h", d, {12'h00E, l2[27:24]}); end
  endtask

  task automatic test_write_cmd();
    logic [15:0] d;
    logic [27:0] l;
    int bad;
    l = 28'($urandom_range(0, 28'h0FFFFF0));
    issue(8'd1, l, 4'hE, 8'h30);
    rd(1, 3'd6, d);
    checks++; if (d !== 16'h0058) begin errors++; $display("FAIL wr_drq got %h exp 0058", d); end
    checks++; if (ide_irq !== 1'b0) begin errors++; $display("FAIL wr_no_irq got %b exp 0", ide_irq); end
    for (int i = 0; i < 256; i++) begin
      sector[i] = 16'hA5A5 + 16'(i);
      wr(0, 3'd0, sector[i]);
    end
    wait_req("wr_drain");
    rd(1, 3'd6, d);
    checks++; if (d !== 16'h0080) begin errors++; $display("FAIL wr_busy got %h exp 0080", d); end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      host_addr = 8'(i);
      @(negedge clock);
      checks++;
      if (host_rdata !== sector[i]) begin
        errors++;
        if (bad++ < 4) $display("FAIL wr_readback w%0d got %h exp %h", i, host_rdata, sector[i]);
      end
    end
    pulse_done(1'b0);
    checks++; if (ide_irq !== 1'b1) begin errors++; $display("FAIL wr_irq got %b exp 1", ide_irq); end
    checks++; if (host_lba !== l + 28'd1) begin errors++; $display("FAIL wr_lba got %h exp %h", host_lba, l + 28'd1); end
    rd(0, 3'd7, d);
    checks++; if (d !== 16'h0050) begin errors++; $display("FAIL wr_end_status got %h exp 0050", d); end
  endtask

  task automatic test_quick();
    logic [15:0] d;
    wr(0, 3'd7, 16'h00EF);
    checks++; if (ide_irq !== 1'b1) begin errors++; $display("FAIL quick_irq got %b exp 1", ide_irq); end
    checks++; if (host_req !== 1'b0) begin errors++; $display("FAIL quick_req got %b exp 0", host_req); end
    rd(0, 3'd7, d);
    checks++; if (d !== 16'h0050) begin errors++; $display("FAIL quick_status got %h exp 0050", d); end
  endtask

  task automatic test_abort();
    logic [15:0] d;
    logic [7:0] devs [2];
    logic [7:0] cmds [2];
    devs = '{8'hA0, 8'hE0};
    cmds = '{8'h20, 8'h55};
    for (int k = 0; k < 2; k++) begin
      wr(0, 3'd6, {8'h00, devs[k]});
      wr(0, 3'd7, {8'h00, cmds[k]});
      checks++; if (ide_irq !== 1'b1) begin errors++; $display("FAIL abort%0d_irq got %b exp 1", k, ide_irq); end
      checks++; if (host_req !== 1'b0) begin errors++; $display("FAIL abort%0d_req got %b exp 0", k, host_req); end
      rd(0, 3'd1, d);
      checks++; if (d !== 16'h0004) begin errors++; $display("FAIL abort%0d_error got %h exp 0004", k, d); end
      rd(1, 3'd6, d);
      checks++; if (d !== 16'h0051) begin errors++; $display("FAIL abort%0d_alt got %h exp 0051", k, d); end
      checks++; if (ide_irq !== 1'b1) begin errors++; $display("FAIL abort%0d_alt_keeps_irq got %b exp 1", k, ide_irq); end
      rd(0, 3'd7, d);
      checks++; if (ide_irq !== 1'b0) begin errors++; $display("FAIL abort%0d_irq_clr got %b exp 0", k, ide_irq); end
    end
  endtask

  task automatic test_host_error();
    logic [15:0] d;
    issue(8'd1, 28'($urandom), 4'hE, 8'h21);
    wait_req("herr_req");
    pulse_done(1'b1);
    checks++; if (ide_irq !== 1'b1) begin errors++; $display("FAIL herr_irq got %b exp 1", ide_irq); end
    checks++; if (host_req !== 1'b0) begin errors++; $display("FAIL herr_req got %b exp 0", host_req); end
    rd(0, 3'd7, d);
    checks++; if (d !== 16'h0051) begin errors++; $display("FAIL herr_status got %h exp 0051", d); end
    rd(0, 3'd1, d);
    checks++; if (d !== 16'h0004) begin errors++; $display("FAIL herr_error got %h exp 0004", d); end
  endtask

  task automatic test_srst();
    logic [15:0] d;
    logic [7:0] exp_regs [8];
    exp_regs = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'hE0, 8'h50};
    issue(8'd3, 28'($urandom), 4'hE, 8'h20);
    wait_req("srst_req");
    host_fill(1'b1);
    pulse_done(1'b0);
    rd(0, 3'd7, d);
    for (int i = 0; i < 10; i++) begin
      rd(0, 3'd0, d);
      checks++; if (d !== sector[i]) begin errors++; $display("FAIL srst_pre w%0d got %h exp %h", i, d, sector[i]); end
    end
    wr(1, 3'd6, 16'h0004);
    rd(1, 3'd6, d);
    checks++; if (d !== 16'h0080) begin errors++; $display("FAIL srst_busy got %h exp 0080", d); end
    checks++; if (host_req !== 1'b0) begin errors++; $display("FAIL srst_req got %b exp 0", host_req); end
    wr(1, 3'd6, 16'h0000);
    for (int r = 1; r < 8; r++) begin
      rd(0, 3'(r), d);
      checks++;
      if (d !== {8'h00, exp_regs[r]}) begin errors++; $display("FAIL srst_reg%0d got %h exp %h", r, d, {8'h00, exp_regs[r]}); end
    end
    checks++; if (host_req !== 1'b0) begin errors++; $display("FAIL srst_req_after got %b exp 0", host_req); end
    checks++; if (ide_irq !== 1'b0) begin errors++; $display("FAIL srst_irq got %b exp 0", ide_irq); end
  endtask

  task automatic test_nien_wrap();
    logic [15:0] d;
    int bad;
    wr(1, 3'd6, 16'h0002);
    irq_mon = 1'b1;
    issue(8'd1, 28'hFFFFFFF, 4'hE, 8'h20);
    wait_req("nien_req");
    host_fill(1'b1);
    pulse_done(1'b0);
    checks++; if (ide_irq !== 1'b0) begin errors++; $display("FAIL nien_irq got %b exp 0", ide_irq); end
    rd(1, 3'd6, d);
    checks++; if (d !== 16'h0058) begin errors++; $display("FAIL nien_drq got %h exp 0058", d); end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      rd(0, 3'd0, d);
      checks++;
      if (d !== sector[i]) begin
        errors++;
        if (bad++ < 4) $display("FAIL nien_data w%0d got %h exp %h", i, d, sector[i]);
      end
    end
    checks++; if (host_lba !== 28'd0) begin errors++; $display("FAIL wrap_host_lba got %h exp 0", host_lba); end
    rd(0, 3'd5, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL wrap_lba2 got %h exp 0000", d); end
    rd(0, 3'd6, d);
    checks++; if (d !== 16'h00E0) begin errors++; $display("FAIL wrap_dev got %h exp 00E0", d); end
    rd(0, 3'd7, d);
    checks++; if (d !== 16'h0050) begin errors++; $display("FAIL nien_end_status got %h exp 0050", d); end
    irq_mon = 1'b0;
    @(negedge clock);
    checks++; if (irq_seen !== 1'b0) begin errors++; $display("FAIL nien_irq_seen got %b exp 0", irq_seen); end
    wr(1, 3'd6, 16'h0000);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_cmd();
    test_write_cmd();
    test_quick();
    test_abort();
    test_host_error();
    test_srst();
    test_nien_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
